// File: rtl/s_pe_out_sink.sv
// s_pe_out_sink
//   Collects a job of len results from the last PE of the array and re-emits
//   them as a ready/valid stream. Results land in a small FIFO. The array is
//   stalled (pea_ready_o=0) whenever the FIFO is full or no job is running.
//   The final result of a job carries a last tag. done_o pulses for one cycle
//   after that tagged entry has been handed downstream.
//
// Handshakes:
//   PE side:         a result moves when pe_valid_i && pea_ready_o at a rising
//                    edge. The producer holds pe_res_i/pe_valid_i while stalled.
//                    pea_ready_o comes from registered state only.
//   Downstream side: a beat moves when m_valid_o && m_ready_i at a rising edge.
//                    m_data_o/m_last_o are held while m_valid_o && !m_ready_i.
//
// Ports:
//   clk_i, rst_n_i       clock (rising edge), async active-low reset
//   start_i, len_i       job start pulse and result count (used only in IDLE)
//   pe_res_i, pe_valid_i result input from the PE array
//   pea_ready_o          array advance enable (stall control)
//   m_data_o, m_valid_o, m_ready_i, m_last_o   downstream stream
//   busy_o, done_o       job status (busy in RUN/DRAIN, done pulse)
//   stall_cycles_o       RUN cycles spent with the array stalled
//   state_o              FSM state for debug (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Build option:
//   S_PE_OUT_SINK_STALL_CNT_EN  enables the saturating stall counter. When it
//                               is undefined, stall_cycles_o is tied to 0.

package pea_pkg;
  localparam int N_BITS = 32;
endpackage

module s_pe_out_sink #(
  parameter int N_BITS     = pea_pkg::N_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [15:0]       len_i,
  input  logic [N_BITS-1:0] pe_res_i,
  input  logic              pe_valid_i,
  output logic              pea_ready_o,
  output logic [N_BITS-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       stall_cycles_o,
  output logic [1:0]        state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic [15:0]       len_q, acc_cnt_q;
  logic [N_BITS-1:0] data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;

  logic fifo_full, fifo_empty, push, pop, start_acc, last_acc;

  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Depends only on state_q and count_q, so no path from pe_valid_i or m_ready_i.
  assign pea_ready_o = (state_q == RUN) && !fifo_full;
  assign push        = pe_valid_i && pea_ready_o;
  assign m_valid_o   = !fifo_empty;
  assign pop         = m_valid_o && m_ready_i;
  assign start_acc   = (state_q == IDLE) && start_i;
  // This accept brings the count up to len. It carries the last tag.
  assign last_acc    = push && ((acc_cnt_q + 16'd1) == len_q);

  // Force the outputs to 0 when the FIFO is empty. Then the unreset storage
  // never shows on the outputs after reset.
  assign m_data_o = m_valid_o ? data_mem[rd_ptr_q] : '0;
  assign m_last_o = m_valid_o && last_mem[rd_ptr_q];

  assign busy_o  = (state_q == RUN) || (state_q == DRAIN);
  assign done_o  = (state_q == DONE);
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i == 16'd0) ? DONE : RUN;
      RUN:     if (last_acc) state_d = DRAIN;
      DRAIN:   if (pop && m_last_o) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      len_q     <= '0;
      acc_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        len_q     <= len_i;
        acc_cnt_q <= '0;
      end else if (push) begin
        acc_cnt_q <= acc_cnt_q + 16'd1;
      end
      // The pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage. It has no reset because m_valid_o gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= pe_res_i;
      last_mem[wr_ptr_q] <= last_acc;
    end
  end

`ifdef S_PE_OUT_SINK_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if ((state_q == RUN) && !pea_ready_o && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_s_pe_out_sink.sv
// Self-checking bench for s_pe_out_sink (FIFO_DEPTH=4, N_BITS=32).
// Inputs are driven and outputs are sampled on the falling edge.
// src_q holds the results the producer still has to offer.
// exp_q holds the stream the downstream side should see, in order.

module tb_s_pe_out_sink;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] len_i = '0;
  logic [31:0] pe_res_i = '0;
  logic        pe_valid_i = 1'b0;
  logic        pea_ready_o;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic        m_last_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] stall_cycles_o;
  logic [1:0]  state_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] src_q[$];

  s_pe_out_sink #(.N_BITS(32), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .len_i(len_i),
    .pe_res_i(pe_res_i), .pe_valid_i(pe_valid_i), .pea_ready_o(pea_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o),
    .stall_cycles_o(stall_cycles_o), .state_o(state_o)
  );

  // Clock generation.
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------

  // Pulse start for one cycle. Returns at the next falling edge.
  task automatic start_job(input logic [15:0] len);
    start_i = 1'b1;
    len_i   = len;
    @(negedge clk_i);
    start_i = 1'b0;
    len_i   = '0;
  endtask

  // Offer src_q as the producer and act as the consumer, one cycle per loop.
  // gap=1 offers results only on even cycles. m_ready_i goes high from cycle
  // ready_from. A start with len 9 pulses at cycle start_at (-1 means never).
  task automatic run_job(input int gap, input int ready_from, input int start_at,
                         input int budget, output int n_done);
    int idx;
    bit want_done;
    bit exp_last;
    logic [31:0] e;
    idx = 0;
    want_done = 0;
    n_done = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      m_ready_i = (cyc >= ready_from);
      start_i   = (cyc == start_at);
      len_i     = (cyc == start_at) ? 16'd9 : 16'd0;
      if (idx < src_q.size() && (gap == 0 || (cyc % 2) == 0)) begin
        pe_valid_i = 1'b1;
        pe_res_i   = src_q[idx];
      end else begin
        pe_valid_i = 1'b0;
        pe_res_i   = 32'hDEAD_BEEF;
      end
      if (done_o === 1'b1) n_done++;
      if (want_done) begin
        total++;
        if (done_o !== 1'b1) begin
          bad++;
          $display("FAIL done_after_last_pop: got %0b expected 1", done_o);
        end
        want_done = 0;
      end
      if (m_valid_o === 1'b1 && m_ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_pop: got data %0h expected no beat", m_data_o);
        end else begin
          e = exp_q.pop_front();
          exp_last = (exp_q.size() == 0);
          if (m_data_o !== e || m_last_o !== exp_last) begin
            bad++;
            $display("FAIL stream_beat: got data=%0h last=%0b expected data=%0h last=%0b",
                     m_data_o, m_last_o, e, exp_last);
          end
          if (exp_last) want_done = 1;
        end
      end
      if (pea_ready_o === 1'b1 && pe_valid_i) idx++;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    len_i = '0;
    pe_valid_i = 1'b0;
    m_ready_i = 1'b0;
    total++;
    if (exp_q.size() != 0 || idx != src_q.size()) begin
      bad++;
      $display("FAIL job_complete: got left=%0d offered=%0d expected left=0 offered=%0d",
               exp_q.size(), idx, src_q.size());
    end
  endtask

  // ---------------------------------------------------------------------
  // Scenario tasks
  // ---------------------------------------------------------------------

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    total++;
    if ({pea_ready_o, m_valid_o, m_last_o, busy_o, done_o} !== 5'b0 ||
        m_data_o !== 32'd0 || stall_cycles_o !== 32'd0 || state_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_values: got rdy=%0b v=%0b l=%0b b=%0b d=%0b data=%0h st=%0h state=%0d expected all 0",
               pea_ready_o, m_valid_o, m_last_o, busy_o, done_o, m_data_o, stall_cycles_o, state_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (pea_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got rdy=%0b busy=%0b expected 0 0", pea_ready_o, busy_o);
    end
  endtask

  task automatic test_basic();
    int n_done;
    src_q = '{32'd10, 32'd11, 32'd12};
    exp_q = '{32'd10, 32'd11, 32'd12};
    start_job(16'd3);
    total++;
    if (busy_o !== 1'b1 || pea_ready_o !== 1'b1 || state_o !== 2'd1) begin
      bad++;
      $display("FAIL basic_run_entry: got busy=%0b rdy=%0b state=%0d expected 1 1 1",
               busy_o, pea_ready_o, state_o);
    end
    run_job(0, 0, -1, 16, n_done);
    total++;
    if (n_done != 1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: got done_pulses=%0d busy=%0b expected 1 0", n_done, busy_o);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int n_done;
    idx = 0;
    start_job(16'd6);
    m_ready_i = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      pe_valid_i = 1'b1;
      pe_res_i   = 32'(idx + 1);
      if (m_valid_o === 1'b1) begin
        total++;
        if (m_data_o !== 32'd1 || m_last_o !== 1'b0) begin
          bad++;
          $display("FAIL hold_head: got data=%0h last=%0b expected 1 0", m_data_o, m_last_o);
        end
      end
      if (pea_ready_o === 1'b1) idx++;
      @(negedge clk_i);
    end
    total++;
    if (idx != 4 || pea_ready_o !== 1'b0 || m_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL full_stall: got accepts=%0d rdy=%0b v=%0b busy=%0b expected 4 0 1 1",
               idx, pea_ready_o, m_valid_o, busy_o);
    end
    total++;
`ifdef S_PE_OUT_SINK_STALL_CNT_EN
    if (stall_cycles_o !== 32'd4) begin
      bad++;
      $display("FAIL stall_count: got %0d expected 4", stall_cycles_o);
    end
`else
    if (stall_cycles_o !== 32'd0) begin
      bad++;
      $display("FAIL stall_count: got %0d expected 0", stall_cycles_o);
    end
`endif
    src_q = '{32'd5, 32'd6};
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    run_job(0, 0, -1, 20, n_done);
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL backpressure_done: got %0d pulses expected 1", n_done);
    end
  endtask

  task automatic test_zero_len();
    start_job(16'd0);
    total++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || m_valid_o !== 1'b0 || pea_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_done: got done=%0b busy=%0b v=%0b rdy=%0b expected 1 0 0 0",
               done_o, busy_o, m_valid_o, pea_ready_o);
    end
    @(negedge clk_i);
    total++;
    if (done_o !== 1'b0 || state_o !== 2'd0 || m_valid_o !== 1'b0 || pea_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_idle: got done=%0b state=%0d v=%0b rdy=%0b expected 0 0 0 0",
               done_o, state_o, m_valid_o, pea_ready_o);
    end
  endtask

  task automatic test_toggle_valid();
    int n_done;
    src_q = '{32'hA5A5_0001, 32'h5A5A_0002};
    exp_q = '{32'hA5A5_0001, 32'h5A5A_0002};
    start_job(16'd2);
    run_job(1, 0, -1, 16, n_done);
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL toggle_done: got %0d pulses expected 1", n_done);
    end
  endtask

  task automatic test_reset_in_drain();
    int n_done;
    int n_valid;
    start_job(16'd2);
    m_ready_i = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      pe_valid_i = (cyc < 2);
      pe_res_i   = 32'(40 + cyc);
      @(negedge clk_i);
    end
    pe_valid_i = 1'b0;
    total++;
    if (state_o !== 2'd2 || m_valid_o !== 1'b1 || m_data_o !== 32'd40 || pea_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL drain_setup: got state=%0d v=%0b data=%0h rdy=%0b expected 2 1 28 0",
               state_o, m_valid_o, m_data_o, pea_ready_o);
    end
    rst_n_i = 1'b0;
    #1;
    total++;
    if ({pea_ready_o, m_valid_o, m_last_o, busy_o, done_o} !== 5'b0 ||
        m_data_o !== 32'd0 || stall_cycles_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_job: got rdy=%0b v=%0b l=%0b b=%0b d=%0b data=%0h st=%0h expected all 0",
               pea_ready_o, m_valid_o, m_last_o, busy_o, done_o, m_data_o, stall_cycles_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    n_done = 0;
    n_valid = 0;
    m_ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      if (done_o === 1'b1) n_done++;
      if (m_valid_o === 1'b1) n_valid++;
    end
    m_ready_i = 1'b0;
    total++;
    if (n_done != 0 || n_valid != 0) begin
      bad++;
      $display("FAIL no_done_after_reset: got done=%0d valid=%0d expected 0 0", n_done, n_valid);
    end
    src_q = '{32'd77};
    exp_q = '{32'd77};
    start_job(16'd1);
    run_job(0, 0, -1, 10, n_done);
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL restart_done: got %0d pulses expected 1", n_done);
    end
  endtask

  task automatic test_start_ignored();
    int n_done;
    src_q = '{32'd20, 32'd21, 32'd22};
    exp_q = '{32'd20, 32'd21, 32'd22};
    start_job(16'd3);
    run_job(0, 0, 1, 16, n_done);
    total++;
    if (n_done != 1 || busy_o !== 1'b0 || state_o !== 2'd0) begin
      bad++;
      $display("FAIL start_in_run: got done=%0d busy=%0b state=%0d expected 1 0 0",
               n_done, busy_o, state_o);
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_toggle_valid();
    test_reset_in_drain();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
